drive_cmd_sequencer: RTL and testbench

DRIVE_CMD_SEQUENCER -- requirements
Module: drive_cmd_sequencer

---
 rtl/drive_pkg.sv | 35 +++
 rtl/cmd_fifo.sv | 73 +++++++
 rtl/drive_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_drive_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types for the drive command sequencer: direction codes, FSM states,
// queued command payload and small direction helpers.
package drive_pkg;

  localparam int unsigned FRAME_CYCLES_DEF = 200;
  localparam int unsigned DUR_W            = 8;

  typedef enum logic [1:0] {
    DIR_FWD  = 2'b01,
    DIR_BACK = 2'b10,
    DIR_STOP = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_GUARD = 2'b10
  } state_t;

  typedef struct packed {
    dir_t             dir;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  // The illegal code 00 is treated as a stop request.
  function automatic dir_t sanitize_dir(logic [1:0] d);
    return (d == 2'b00) ? DIR_STOP : dir_t'(d);
  endfunction

  function automatic logic is_reversal(dir_t cur, dir_t nxt);
    return ((cur == DIR_FWD) && (nxt == DIR_BACK)) ||
           ((cur == DIR_BACK) && (nxt == DIR_FWD));
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command buffer: power-of-two depth circular FIFO of {dir, dur} entries
// with registered count/full/empty and a synchronous clear.
module cmd_fifo
  import drive_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  cmd_t                     wdata_i,
  output cmd_t                     head_c,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign head_c  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      full_o  <= (cnt_d == CW'(DEPTH));
      empty_o <= (cnt_d == '0);
      if (clr_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + AW'(1);
        if (do_pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/drive_cmd_sequencer.sv
// Frame-synchronous motor command sequencer: queues direction/duration
// commands and replays them to the driver, inserting a guard frame on reversal.
module drive_cmd_sequencer
  import drive_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [1:0]                    cmd_dir,
  input  logic [7:0]                    cmd_dur,
  output logic                          cmd_ready,
  input  logic                          abort,
  output logic [1:0]                    instr,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CNT_W-1:0] frame_q;
  logic             frame_tick_c;
  state_t           state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  dir_t             dir_q, dir_d;
  dir_t             instr_q, instr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       pending_q, pending_d;
  logic [2:0]       owe_c;
  logic             pop_c;
  logic             complete_c;
  logic             accept_c;
  logic             null_c;
  logic             push_c;
  cmd_t             wcmd_c;
  cmd_t             head_c;
  logic             fifo_full;
  logic             fifo_empty;

  assign frame_tick_c = (frame_q == CNT_W'(FRAME_CYCLES - 1));
  assign cmd_ready    = !fifo_full && !abort;
  assign accept_c     = cmd_valid && cmd_ready;
  assign null_c       = accept_c && (cmd_dur == '0);
  assign push_c       = accept_c && (cmd_dur != '0);
  assign wcmd_c.dir   = sanitize_dir(cmd_dir);
  assign wcmd_c.dur   = cmd_dur;

  assign instr = instr_q;
  assign busy  = busy_q;
  assign done  = done_q;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (abort),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wcmd_c),
    .head_c  (head_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Free-running frame phase; only reset restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_tick_c ? '0 : frame_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      dir_q     <= DIR_STOP;
      instr_q   <= DIR_STOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    pop_c      = 1'b0;
    complete_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick_c && !fifo_empty) begin
          pop_c   = 1'b1;
          rem_d   = head_c.dur;
          dir_d   = head_c.dir;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_tick_c) begin
          if (rem_q > DUR_W'(1)) begin
            rem_d = rem_q - DUR_W'(1);
          end else begin
            complete_c = 1'b1;
            if (fifo_empty) begin
              state_d = ST_IDLE;
            end else begin
              // A reversal is parked for one full stop frame before it runs.
              pop_c   = 1'b1;
              rem_d   = head_c.dur;
              dir_d   = head_c.dir;
              state_d = is_reversal(dir_q, head_c.dir) ? ST_GUARD : ST_RUN;
            end
          end
        end
      end
      ST_GUARD: begin
        if (frame_tick_c) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      pop_c      = 1'b0;
      complete_c = 1'b0;
    end

    instr_d = (state_d == ST_RUN) ? dir_d : DIR_STOP;
    busy_d  = (state_d != ST_IDLE);

    // Completions and null drops each owe one done pulse; colliding ones are deferred.
    owe_c     = 3'(complete_c) + 3'(null_c) + 3'(pending_q);
    done_d    = (owe_c != 3'd0);
    pending_d = (owe_c == 3'd0) ? 2'd0 : 2'(owe_c - 3'd1);
    if (abort) begin
      done_d    = 1'b0;
      pending_d = 2'd0;
    end
  end

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Self-checking bench for drive_cmd_sequencer against a queue-based frame model.
module tb_drive_cmd_sequencer;

  localparam int FC    = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_dir = 2'd0;
  logic [7:0] cmd_dur = 8'd0;
  logic       abort = 1'b0;
  logic       cmd_ready;
  logic [1:0] instr;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int   q_dir[$];
  int   q_dur[$];
  int   phase, mode, cur_dir, left, owed;
  logic [1:0] e_instr;
  logic e_busy, e_done, e_ready;
  int   e_cnt;
  logic got_ready;

  drive_cmd_sequencer #(
    .FRAME_CYCLES (FC),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_dur    (cmd_dur),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .instr      (instr),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q_dir.delete(); q_dur.delete();
    phase = 0; mode = 0; cur_dir = 3; left = 0; owed = 0;
    e_instr = 2'd3; e_busy = 1'b0; e_done = 1'b0; e_cnt = 0; e_ready = 1'b1;
  endtask

  // One clock of behaviour: mode 0 idle, 1 running, 2 guard frame.
  task automatic model_step(input bit v, input int dir, input int dur, input bit ab);
    bit tick;
    bit comp;
    int nd;
    tick = (phase == FC - 1);
    comp = 0;
    e_ready = (q_dir.size() < DEPTH) && !ab;
    if (ab) begin
      q_dir.delete(); q_dur.delete();
      mode = 0; owed = 0; e_done = 1'b0;
    end else begin
      if (tick) begin
        if (mode == 0) begin
          if (q_dir.size() > 0) begin
            cur_dir = q_dir.pop_front(); left = q_dur.pop_front(); mode = 1;
          end
        end else if (mode == 2) begin
          mode = 1;
        end else if (left > 1) begin
          left--;
        end else begin
          comp = 1;
          if (q_dir.size() == 0) begin
            mode = 0;
          end else begin
            nd = q_dir[0];
            mode = ((cur_dir == 1 && nd == 2) || (cur_dir == 2 && nd == 1)) ? 2 : 1;
            cur_dir = q_dir.pop_front(); left = q_dur.pop_front();
          end
        end
      end
      if (v && e_ready) begin
        if (dur == 0) owed++;
        else begin
          q_dir.push_back(dir == 0 ? 3 : dir);
          q_dur.push_back(dur);
        end
      end
      if (comp) owed++;
      e_done = (owed > 0);
      if (owed > 0) owed--;
    end
    phase = (phase + 1) % FC;
    e_instr = (mode == 1) ? 2'(cur_dir) : 2'd3;
    e_busy = (mode != 0);
    e_cnt = q_dir.size();
  endtask

  task automatic step(input bit v, input int dir, input int dur, input bit ab);
    cmd_valid = v; cmd_dir = dir[1:0]; cmd_dur = dur[7:0]; abort = ab;
    #1;
    got_ready = cmd_ready;
    model_step(v, dir, dur, ab);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; abort = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++; if (instr !== 2'd3) begin failures++; $display("FAIL reset_instr got %0d want 3", instr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0d want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %0d want 0", done); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    do_reset();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %0d want 1", cmd_ready); end
  endtask

  task automatic test_single();
    int n_fwd, n_busy, n_done;
    n_fwd = 0; n_busy = 0; n_done = 0;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      step(c == 0, 1, 3, 0);
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL single_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
      n_fwd += (instr == 2'd1); n_busy += busy; n_done += done;
    end
    checks++; if (n_fwd != 30) begin failures++; $display("FAIL single_fwd_cycles got %0d want 30", n_fwd); end
    checks++; if (n_busy != 30) begin failures++; $display("FAIL single_busy_cycles got %0d want 30", n_busy); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL single_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_reversal();
    int n_fwd, n_back, n_done, last_fwd, first_back;
    n_fwd = 0; n_back = 0; n_done = 0; last_fwd = -1; first_back = -1;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      step(c < 2, (c == 0) ? 1 : 2, 2, 0);
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL rev_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
      if (instr == 2'd1) begin n_fwd++; last_fwd = c; end
      if (instr == 2'd2) begin n_back++; if (first_back < 0) first_back = c; end
      n_done += done;
    end
    checks++; if (n_fwd != 20 || n_back != 20) begin failures++; $display("FAIL rev_frames got fwd=%0d back=%0d want 20/20", n_fwd, n_back); end
    checks++; if (first_back - last_fwd != 11) begin failures++; $display("FAIL rev_guard_gap got %0d want 11", first_back - last_fwd); end
    checks++; if (n_done != 2) begin failures++; $display("FAIL rev_done_pulses got %0d want 2", n_done); end
  endtask

  task automatic test_full();
    int sent, peak, fifth_at;
    bit ready4;
    sent = 0; peak = 0; fifth_at = -1; ready4 = 1'b1;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      step(sent < 5, (sent % 2) + 1, 1, 0);
      checks++;
      if (got_ready !== e_ready) begin failures++; $display("FAIL full_ready c=%0d got %0d want %0d", c, got_ready, e_ready); end
      if (c == 4) ready4 = got_ready;
      if (sent < 5 && got_ready) begin
        if (sent == 4) fifth_at = c;
        sent++;
      end
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL full_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    checks++; if (ready4 !== 1'b0) begin failures++; $display("FAIL full_ready_after4 got %0d want 0", ready4); end
    checks++; if (fifth_at != FC) begin failures++; $display("FAIL full_fifth_accept got %0d want %0d", fifth_at, FC); end
    checks++; if (peak != 4) begin failures++; $display("FAIL full_peak got %0d want 4", peak); end
  endtask

  task automatic test_null();
    do_reset();
    step(1, 2, 0, 0);
    checks++; if ({instr, done, fifo_count} !== {2'd3, 1'b1, 3'd0}) begin
      failures++; $display("FAIL null_pulse got %h want %h", {instr, done, fifo_count}, {2'd3, 1'b1, 3'd0});
    end
    step(0, 0, 0, 0);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL null_single got %0d want 0", done); end
  endtask

  task automatic test_abort();
    bit v;
    int d, u;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      v = (c < 3) || (c == 25);
      d = (c == 2) ? 2 : 1;
      u = (c == 0) ? 5 : 1;
      step(v, d, u, c == 24);
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL abort_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
      if (c == 24) begin
        checks++; if ({instr, busy, done, fifo_count} !== {2'd3, 1'b0, 1'b0, 3'd0}) begin
          failures++; $display("FAIL abort_flush got %h want %h", {instr, busy, done, fifo_count}, {2'd3, 1'b0, 1'b0, 3'd0});
        end
      end
      if (c == 29) begin
        checks++; if (instr !== 2'd1) begin failures++; $display("FAIL abort_phase got %0d want 1", instr); end
      end
    end
  endtask

  task automatic test_long();
    int n_busy, n_done;
    n_busy = 0; n_done = 0;
    do_reset();
    for (int c = 0; c < 2575; c++) begin
      step(c == 0, 2, 255, 0);
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL long_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
      n_busy += busy; n_done += done;
    end
    checks++; if (n_busy != 2550) begin failures++; $display("FAIL long_busy_cycles got %0d want 2550", n_busy); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL long_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_random();
    bit v, ab;
    int d, u;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v  = 1'($urandom_range(0, 1));
      d  = int'($urandom_range(0, 3));
      u  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 39) == 0);
      step(v, d, u, ab);
      checks++;
      if (got_ready !== e_ready) begin failures++; $display("FAIL rand_ready c=%0d got %0d want %0d", c, got_ready, e_ready); end
      checks++;
      if ({instr, busy, done, fifo_count} !== {e_instr, e_busy, e_done, 3'(e_cnt)}) begin
        failures++; $display("FAIL rand_outs c=%0d got %h want %h", c, {instr, busy, done, fifo_count}, {e_instr, e_busy, e_done, 3'(e_cnt)});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 25; c++) step(c == 0, 1, 3, 0);
    checks++; if (instr !== 2'd1) begin failures++; $display("FAIL mid_running got %0d want 1", instr); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({instr, busy, done, fifo_count} !== {2'd3, 1'b0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL mid_async_reset got %h want %h", {instr, busy, done, fifo_count}, {2'd3, 1'b0, 1'b0, 3'd0});
    end
    do_reset();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got %0d want 1", cmd_ready); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_reversal();
    test_full();
    test_null();
    test_abort();
    test_long();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
